elevator_controller: RTL and testbench

Serves the two elevator shafts (left: floors 0–5, right: floors 0–5). It latches the 12 hall-call lines raised by waiting people and moves each car with a collective up/down sweep, opening its doors at requested floors. It reports each car's current floor on `elevatorStates`, which the people controller compares to decide boarding and drop-off. It is the responder side of the `floorsRequested`/`elevatorStates` exchange.

---
 rtl/elevator_pkg.sv | 45 ++++
 rtl/elevator_car.sv | 170 +++++++++++++++++
 rtl/elevator_controller.sv | 58 +++++
 tb/tb_elevator_controller.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the two-shaft elevator controller.
// Holds the simulation-phase and car-state encodings plus the sweep direction rule.
package elevator_pkg;

  typedef enum logic [1:0] {
    START  = 2'd0,
    SIM    = 2'd1,
    PAUSE  = 2'd2,
    ENDING = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DOORS  = 2'd2
  } car_state_e;

  localparam int         NUM_FLOORS = 6;
  localparam logic [2:0] TOP_FLOOR  = 3'd5;

  // Collective sweep: keep going while calls lie ahead, turn for calls behind,
  // otherwise patrol between the end floors.
  function automatic logic next_dir(input logic [2:0] floor,
                                    input logic       dir,
                                    input logic [5:0] pend);
    logic [5:0] above;
    logic [5:0] below;
    logic       ahead;
    logic       behind;
    above = '0;
    below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor)) above[i] = pend[i];
      if (i < int'(floor)) below[i] = pend[i];
    end
    ahead  = dir ? |above : |below;
    behind = dir ? |below : |above;
    if (ahead)                   return dir;
    else if (behind)             return ~dir;
    else if (floor == TOP_FLOOR) return 1'b0;
    else if (floor == 3'd0)      return 1'b1;
    else                         return dir;
  endfunction

endpackage

// File: rtl/elevator_car.sv
// One elevator car: sweep FSM, travel/dwell accumulators and its six hall-call latches.
//
//   state  | meaning
//   IDLE   | parked; leaves on the next SIM cycle (or stays at floor 0 when ending)
//   MOVING | accumulating travel; one floor step each time the threshold is reached
//   DOORS  | doors open at the current floor until the dwell threshold is reached
module elevator_car
  import elevator_pkg::*;
#(
  parameter logic [19:0] FLOOR_CYCLES = 20'd1000000,
  parameter logic [19:0] DOOR_CYCLES  = 20'd500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] simState,
  input  logic [1:0] simSpeed,
  input  logic [5:0] req,
  output logic [2:0] floor,
  output logic       doorOpen,
  output logic [5:0] pending
);

  car_state_e  state_q, state_d;
  logic        dir_q, dir_d;
  logic [2:0]  floor_q, floor_d;
  logic [19:0] acc_q, acc_d;
  logic [19:0] dwell_q, dwell_d;
  logic [5:0]  pending_q, pending_d;

  logic [19:0] inc;
  logic [20:0] travel_sum;
  logic [20:0] dwell_sum;
  logic        travel_done;
  logic        dwell_done;
  logic        step_dir;
  logic [2:0]  new_floor;
  logic [5:0]  cur_mask;
  logic [5:0]  new_mask;

  always_comb begin
    inc         = {18'd0, simSpeed} + 20'd1;
    travel_sum  = {1'b0, acc_q} + {1'b0, inc};
    dwell_sum   = {1'b0, dwell_q} + {1'b0, inc};
    travel_done = travel_sum >= {1'b0, FLOOR_CYCLES};
    dwell_done  = dwell_sum >= {1'b0, DOOR_CYCLES};
    // The end floors force the direction before a step so the floor never leaves 0..5.
    if (floor_q == TOP_FLOOR)  step_dir = 1'b0;
    else if (floor_q == 3'd0)  step_dir = 1'b1;
    else                       step_dir = dir_q;
    new_floor = step_dir ? floor_q + 3'd1 : floor_q - 3'd1;
    cur_mask  = 6'd1 << floor_q;
    new_mask  = 6'd1 << new_floor;
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    floor_d   = floor_q;
    acc_d     = acc_q;
    dwell_d   = dwell_q;
    pending_d = pending_q;

    case (state_e'(simState))
      START: begin
        state_d   = IDLE;
        dir_d     = 1'b1;
        floor_d   = 3'd0;
        acc_d     = '0;
        dwell_d   = '0;
        pending_d = '0;
      end

      SIM: begin
        pending_d = pending_q | req;
        if (state_q == DOORS) pending_d = pending_d & ~cur_mask;
        case (state_q)
          IDLE: begin
            state_d = MOVING;
            dir_d   = next_dir(floor_q, dir_q, pending_q);
          end
          MOVING: begin
            if (travel_done) begin
              acc_d   = '0;
              floor_d = new_floor;
              if ((pending_q & new_mask) != 6'd0) begin
                state_d   = DOORS;
                dir_d     = step_dir;
                pending_d = pending_d & ~new_mask;
              end else begin
                dir_d = next_dir(new_floor, step_dir, pending_q);
              end
            end else begin
              acc_d = travel_sum[19:0];
            end
          end
          DOORS: begin
            if (dwell_done) begin
              dwell_d = '0;
              state_d = MOVING;
              dir_d   = next_dir(floor_q, dir_q, pending_q);
            end else begin
              dwell_d = dwell_sum[19:0];
            end
          end
          default: state_d = IDLE;
        endcase
      end

      ENDING: begin
        pending_d = '0;
        case (state_q)
          IDLE: begin
            if (floor_q != 3'd0) begin
              state_d = MOVING;
              dir_d   = 1'b0;
            end
          end
          MOVING: begin
            dir_d = 1'b0;
            if (floor_q == 3'd0) begin
              state_d = IDLE;
              acc_d   = '0;
            end else if (travel_done) begin
              acc_d   = '0;
              floor_d = floor_q - 3'd1;
              if (floor_q == 3'd1) state_d = IDLE;
            end else begin
              acc_d = travel_sum[19:0];
            end
          end
          DOORS: begin
            if (dwell_done) begin
              dwell_d = '0;
              state_d = MOVING;
              dir_d   = 1'b0;
            end else begin
              dwell_d = dwell_sum[19:0];
            end
          end
          default: state_d = IDLE;
        endcase
      end

      default: ;  // PAUSE freezes everything, including the call latches
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= 1'b1;
      floor_q   <= 3'd0;
      acc_q     <= '0;
      dwell_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      acc_q     <= acc_d;
      dwell_q   <= dwell_d;
      pending_q <= pending_d;
    end
  end

  assign floor    = floor_q;
  assign doorOpen = (state_q == DOORS);
  assign pending  = pending_q;

endmodule

// File: rtl/elevator_controller.sv
// Two-shaft elevator controller: left car serves hall calls [5:0], right car [11:6].
// Reports both car floors to the people controller as {right, left}.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter logic [19:0] FLOOR_CYCLES = 20'd1000000,
  parameter logic [19:0] DOOR_CYCLES  = 20'd500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  simState,
  input  logic [1:0]  simSpeed,
  input  logic [11:0] floorsRequested,
  output logic [5:0]  elevatorStates,
  output logic [1:0]  doorsOpen,
  output logic [11:0] pendingRequests
);

  logic [2:0] left_floor;
  logic [2:0] right_floor;
  logic       left_door;
  logic       right_door;
  logic [5:0] left_pend;
  logic [5:0] right_pend;

  elevator_car #(
    .FLOOR_CYCLES(FLOOR_CYCLES),
    .DOOR_CYCLES (DOOR_CYCLES)
  ) u_left (
    .clk     (clk),
    .rst     (rst),
    .simState(simState),
    .simSpeed(simSpeed),
    .req     (floorsRequested[5:0]),
    .floor   (left_floor),
    .doorOpen(left_door),
    .pending (left_pend)
  );

  elevator_car #(
    .FLOOR_CYCLES(FLOOR_CYCLES),
    .DOOR_CYCLES (DOOR_CYCLES)
  ) u_right (
    .clk     (clk),
    .rst     (rst),
    .simState(simState),
    .simSpeed(simSpeed),
    .req     (floorsRequested[11:6]),
    .floor   (right_floor),
    .doorOpen(right_door),
    .pending (right_pend)
  );

  assign elevatorStates  = {right_floor, left_floor};
  assign doorsOpen       = {right_door, left_door};
  assign pendingRequests = {right_pend, left_pend};

endmodule

// File: tb/tb_elevator_controller.sv
// Directed vector bench for elevator_controller with FLOOR_CYCLES=8, DOOR_CYCLES=4.
module tb_elevator_controller;

  localparam logic [1:0] S_START  = 2'd0;
  localparam logic [1:0] S_SIM    = 2'd1;
  localparam logic [1:0] S_PAUSE  = 2'd2;
  localparam logic [1:0] S_ENDING = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  simState;
  logic [1:0]  simSpeed;
  logic [11:0] floorsRequested;
  logic [5:0]  elevatorStates;
  logic [1:0]  doorsOpen;
  logic [11:0] pendingRequests;

  always #5 clk = ~clk;

  elevator_controller #(
    .FLOOR_CYCLES(20'd8),
    .DOOR_CYCLES (20'd4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .simState       (simState),
    .simSpeed       (simSpeed),
    .floorsRequested(floorsRequested),
    .elevatorStates (elevatorStates),
    .doorsOpen      (doorsOpen),
    .pendingRequests(pendingRequests)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  st;
    logic [1:0]  spd;
    logic [11:0] req;
    int          cycles;
    logic [5:0]  elev;
    logic [1:0]  doors;
    logic [11:0] pend;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(string name, logic r, logic [1:0] st, logic [1:0] spd,
                              logic [11:0] req, int cycles, logic [5:0] elev,
                              logic [1:0] doors, logic [11:0] pend);
    vec_t v;
    v.name = name; v.rst = r; v.st = st; v.spd = spd; v.req = req;
    v.cycles = cycles; v.elev = elev; v.doors = doors; v.pend = pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int waited;
    int opened;

    rst = 1'b1;
    simState = S_START;
    simSpeed = 2'd0;
    floorsRequested = '0;

    //              name          rst st        spd  req     cyc elev   dr    pend
    vecs.push_back(mk("reset",      1, S_START,  0, 12'h000,  2, 6'h00, 2'd0, 12'h000));
    // single call to left floor 3
    vecs.push_back(mk("sc_latch",   0, S_SIM,    0, 12'h008,  1, 6'h00, 2'd0, 12'h008));
    vecs.push_back(mk("sc_f1",      0, S_SIM,    0, 12'h000,  8, 6'h09, 2'd0, 12'h008));
    vecs.push_back(mk("sc_f2",      0, S_SIM,    0, 12'h000,  8, 6'h12, 2'd0, 12'h008));
    vecs.push_back(mk("sc_doors",   0, S_SIM,    0, 12'h000,  8, 6'h1B, 2'd1, 12'h000));
    vecs.push_back(mk("sc_dwell",   0, S_SIM,    0, 12'h000,  3, 6'h1B, 2'd1, 12'h000));
    vecs.push_back(mk("sc_close",   0, S_SIM,    0, 12'h000,  1, 6'h1B, 2'd0, 12'h000));
    vecs.push_back(mk("sc_curfl",   0, S_SIM,    0, 12'h008,  1, 6'h1B, 2'd0, 12'h008));
    vecs.push_back(mk("sc_r4",      0, S_SIM,    0, 12'h000,  3, 6'h23, 2'd0, 12'h008));
    vecs.push_back(mk("sc_l4",      0, S_SIM,    0, 12'h000,  4, 6'h24, 2'd0, 12'h008));
    // sweep: calls at 1 and 4 while left passes 1 going up
    vecs.push_back(mk("sw_start",   0, S_START,  0, 12'h000,  1, 6'h00, 2'd0, 12'h000));
    vecs.push_back(mk("sw_f1",      0, S_SIM,    0, 12'h000,  9, 6'h09, 2'd0, 12'h000));
    vecs.push_back(mk("sw_req",     0, S_SIM,    0, 12'h012,  1, 6'h09, 2'd0, 12'h012));
    vecs.push_back(mk("sw_f2",      0, S_SIM,    0, 12'h000,  7, 6'h12, 2'd0, 12'h012));
    vecs.push_back(mk("sw_stop4",   0, S_SIM,    0, 12'h000, 16, 6'h24, 2'd1, 12'h002));
    vecs.push_back(mk("sw_leave4",  0, S_SIM,    0, 12'h000,  4, 6'h24, 2'd0, 12'h002));
    vecs.push_back(mk("sw_down3",   0, S_SIM,    0, 12'h000,  8, 6'h2B, 2'd0, 12'h002));
    vecs.push_back(mk("sw_stop1",   0, S_SIM,    0, 12'h000, 16, 6'h19, 2'd1, 12'h000));
    // speed 3: two cycles per floor, one-cycle dwell
    vecs.push_back(mk("sp_start",   0, S_START,  0, 12'h000,  1, 6'h00, 2'd0, 12'h000));
    vecs.push_back(mk("sp_latch",   0, S_SIM,    3, 12'h080,  1, 6'h00, 2'd0, 12'h080));
    vecs.push_back(mk("sp_acc",     0, S_SIM,    3, 12'h000,  1, 6'h00, 2'd0, 12'h080));
    vecs.push_back(mk("sp_f1",      0, S_SIM,    3, 12'h000,  1, 6'h09, 2'd2, 12'h000));
    vecs.push_back(mk("sp_dwell",   0, S_SIM,    3, 12'h000,  1, 6'h09, 2'd0, 12'h000));
    vecs.push_back(mk("sp_l2",      0, S_SIM,    3, 12'h000,  1, 6'h0A, 2'd0, 12'h000));
    vecs.push_back(mk("sp_r2",      0, S_SIM,    3, 12'h000,  1, 6'h12, 2'd0, 12'h000));
    vecs.push_back(mk("sp_l3",      0, S_SIM,    3, 12'h000,  1, 6'h13, 2'd0, 12'h000));
    // pause mid-step
    vecs.push_back(mk("pa_start",   0, S_START,  0, 12'h000,  1, 6'h00, 2'd0, 12'h000));
    vecs.push_back(mk("pa_latch",   0, S_SIM,    0, 12'h010,  1, 6'h00, 2'd0, 12'h010));
    vecs.push_back(mk("pa_acc",     0, S_SIM,    0, 12'h000,  4, 6'h00, 2'd0, 12'h010));
    vecs.push_back(mk("pa_hold",    0, S_PAUSE,  0, 12'h020, 10, 6'h00, 2'd0, 12'h010));
    vecs.push_back(mk("pa_resume",  0, S_SIM,    0, 12'h000,  3, 6'h00, 2'd0, 12'h010));
    vecs.push_back(mk("pa_step",    0, S_SIM,    0, 12'h000,  1, 6'h09, 2'd0, 12'h010));
    // ending with right car dwelling at floor 4
    vecs.push_back(mk("en_start",   0, S_START,  0, 12'h000,  1, 6'h00, 2'd0, 12'h000));
    vecs.push_back(mk("en_latch",   0, S_SIM,    0, 12'h420,  1, 6'h00, 2'd0, 12'h420));
    vecs.push_back(mk("en_doors",   0, S_SIM,    0, 12'h000, 32, 6'h24, 2'd2, 12'h020));
    vecs.push_back(mk("en_clear",   0, S_ENDING, 0, 12'h001,  1, 6'h24, 2'd2, 12'h000));
    vecs.push_back(mk("en_dwell",   0, S_ENDING, 0, 12'h001,  3, 6'h24, 2'd0, 12'h000));
    vecs.push_back(mk("en_l3",      0, S_ENDING, 0, 12'h001,  4, 6'h23, 2'd0, 12'h000));
    vecs.push_back(mk("en_r3",      0, S_ENDING, 0, 12'h001,  4, 6'h1B, 2'd0, 12'h000));
    vecs.push_back(mk("en_2",       0, S_ENDING, 0, 12'h001,  8, 6'h12, 2'd0, 12'h000));
    vecs.push_back(mk("en_1",       0, S_ENDING, 0, 12'h001,  8, 6'h09, 2'd0, 12'h000));
    vecs.push_back(mk("en_l0",      0, S_ENDING, 0, 12'h001,  4, 6'h08, 2'd0, 12'h000));
    vecs.push_back(mk("en_r0",      0, S_ENDING, 0, 12'h001,  4, 6'h00, 2'd0, 12'h000));
    vecs.push_back(mk("en_stay",    0, S_ENDING, 0, 12'h001, 20, 6'h00, 2'd0, 12'h000));
    // reset in the middle of a run
    vecs.push_back(mk("mr_run",     0, S_SIM,    0, 12'h03F,  5, 6'h00, 2'd0, 12'h03F));
    vecs.push_back(mk("mr_rst",     1, S_SIM,    0, 12'h03F,  1, 6'h00, 2'd0, 12'h000));

    foreach (vecs[i]) begin
      rst             = vecs[i].rst;
      simState        = vecs[i].st;
      simSpeed        = vecs[i].spd;
      floorsRequested = vecs[i].req;
      repeat (vecs[i].cycles) @(posedge clk);
      #1;
      check({vecs[i].name, "_floor"}, {6'd0, elevatorStates}, {6'd0, vecs[i].elev});
      check({vecs[i].name, "_doors"}, {10'd0, doorsOpen}, {10'd0, vecs[i].doors});
      check({vecs[i].name, "_pend"}, pendingRequests, vecs[i].pend);
    end

    // Out of reset straight into SIM: call at left floor 1 opens on edge 9 for 4 cycles.
    rst = 1'b0;
    simState = S_SIM;
    simSpeed = 2'd0;
    floorsRequested = 12'h002;
    waited = 0;
    while (waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
      floorsRequested = '0;
      if (doorsOpen[0]) break;
    end
    check("dw_arrive_cycles", waited[11:0], 12'd9);
    opened = 0;
    if (doorsOpen[0]) begin
      opened = 1;
      while (opened < 20) begin
        @(posedge clk);
        #1;
        if (!doorsOpen[0]) break;
        opened++;
      end
    end
    check("dw_open_cycles", opened[11:0], 12'd4);
    check("dw_floor", {6'd0, elevatorStates}, 12'h009);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
